secuenciador_unos: RTL and testbench

//  Front/back stage wrapped around the 3-bit ones counter (cuenta1).

---
 rtl/secuenciador_unos.sv | 155 +++++++++++++++
 tb/tb_secuenciador_unos.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_unos.sv
`default_nettype none
// ============================================================================
// Module   : secuenciador_unos
// Purpose  : Splits a wide word into 3-bit chunks, feeds each chunk to the
//            cuenta1 ones counter over a start/fin handshake, and sums the
//            returned counts into the word's total ones-count.
// Revision : 1.0  initial release
// ============================================================================
module secuenciador_unos #(
    parameter int NCHUNK  = 4,
    parameter int SUMW    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3*NCHUNK-1:0] dato,
    input  logic                go,
    output logic                busy,
    output logic [2:0]          Valor,
    output logic                start,
    input  logic [3:0]          Cuenta,
    input  logic                fin,
    output logic [SUMW-1:0]     total,
    output logic                listo,
    output logic                error
);

    localparam int c_idx_w  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int c_wcnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(NCHUNK - 1);
    localparam logic [c_idx_w-1:0]  c_idx_one  = c_idx_w'(1);
    localparam logic [c_wcnt_w-1:0] c_timeout  = c_wcnt_w'(TIMEOUT);
    localparam logic [c_wcnt_w-1:0] c_wcnt_one = c_wcnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_FIN  = 3'd3,
        S_ACUM      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                r_state;
    logic [3*NCHUNK-1:0]   r_dato;
    logic [c_idx_w-1:0]    r_idx;
    logic [c_wcnt_w-1:0]   r_wcnt;

    logic [2:0]            w_chunk [NCHUNK];
    logic [c_idx_w-1:0]    w_idx_nxt;
    logic                  w_timeout;
    logic                  w_cuenta_bad;

    generate
        for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
            assign w_chunk[g] = r_dato[3*g +: 3];
        end
    endgenerate

    assign w_idx_nxt    = r_idx + c_idx_one;
    assign w_timeout    = (r_wcnt == c_timeout);
    assign w_cuenta_bad = (Cuenta > 4'd3);

    // Outputs are registered: each is loaded on the transition into the state
    // where it must be visible, so start/listo last exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dato  <= '0;
            r_idx   <= '0;
            r_wcnt  <= '0;
            busy    <= 1'b0;
            start   <= 1'b0;
            listo   <= 1'b0;
            error   <= 1'b0;
            total   <= '0;
            Valor   <= 3'd0;
        end else begin
            start <= 1'b0;
            listo <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_dato  <= dato;
                        total   <= '0;
                        error   <= 1'b0;
                        r_idx   <= '0;
                        Valor   <= dato[2:0];
                        start   <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wcnt  <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!fin) begin
                        r_wcnt  <= '0;
                        r_state <= S_WAIT_FIN;
                    end else if (w_timeout) begin
                        error   <= 1'b1;
                        listo   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wcnt <= r_wcnt + c_wcnt_one;
                    end
                end
                S_WAIT_FIN: begin
                    if (fin) begin
                        r_wcnt  <= '0;
                        r_state <= S_ACUM;
                    end else if (w_timeout) begin
                        error   <= 1'b1;
                        listo   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wcnt <= r_wcnt + c_wcnt_one;
                    end
                end
                S_ACUM: begin
                    if (w_cuenta_bad) begin
                        error   <= 1'b1;
                        listo   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        // Cuenta <= 3 here, so the resize cannot lose bits
                        total <= total + SUMW'(Cuenta);
                        if (r_idx == c_last_idx) begin
                            listo   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            Valor   <= w_chunk[w_idx_nxt];
                            start   <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_unos.sv
`default_nettype none
// ============================================================================
// Module   : tb_secuenciador_unos
// Purpose  : Self-checking bench for secuenciador_unos with a cuenta1 responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_secuenciador_unos;

    localparam int NCHUNK  = 4;
    localparam int SUMW    = 4;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [11:0]      dato;
    logic             go;
    logic             busy;
    logic [2:0]       Valor;
    logic             start;
    logic [3:0]       Cuenta = 4'd0;
    logic             fin = 1'b1;
    logic [SUMW-1:0]  total;
    logic             listo;
    logic             error;

    int vectors     = 0;
    int miscompares = 0;

    // Responder behaviour: 0 normal, 1 hung (fin stays high), 3 bad Cuenta on
    // fault_chunk. A stuck-low fin is modelled by a very long delay.
    int mode        = 0;
    int fault_chunk = 0;
    int word_base   = 0;
    int dly [NCHUNK];

    int         rsp_cnt  = 0;
    int         rsp_hold = 0;
    bit         rsp_busy = 1'b0;
    bit         rsp_bad  = 1'b0;
    logic [2:0] rsp_val  = 3'd0;
    int         rsp_k;
    assign rsp_k = rsp_cnt - word_base;

    secuenciador_unos #(
        .NCHUNK  (NCHUNK),
        .SUMW    (SUMW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .dato   (dato),
        .go     (go),
        .busy   (busy),
        .Valor  (Valor),
        .start  (start),
        .Cuenta (Cuenta),
        .fin    (fin),
        .total  (total),
        .listo  (listo),
        .error  (error)
    );

    always #5 clk = ~clk;

    // cuenta1 model: fin drops after a start and rises dly cycles later
    always @(negedge clk) begin
        if (start) begin
            rsp_cnt <= rsp_cnt + 1;
            if (mode != 1) begin
                fin      <= 1'b0;
                rsp_busy <= 1'b1;
                rsp_hold <= (rsp_k >= 0 && rsp_k < NCHUNK) ? dly[rsp_k] : 2;
                rsp_val  <= Valor;
                rsp_bad  <= (mode == 3) && (rsp_k == fault_chunk);
            end
        end else if (rsp_busy) begin
            if (rsp_hold <= 1) begin
                fin      <= 1'b1;
                Cuenta   <= rsp_bad ? 4'd4 : 4'($countones(rsp_val));
                rsp_busy <= 1'b0;
            end else begin
                rsp_hold <= rsp_hold - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_word(input logic [11:0] d, input int fm, input int fch, input bit dup_go);
        logic [2:0] ch [NCHUNK];
        int  exp_total, exp_lat, exp_starts, n, nstart;
        bit  exp_err, seen;
        for (int k = 0; k < NCHUNK; k++) begin
            ch[k]  = d[3*k +: 3];
            dly[k] = $urandom_range(5, 2);
        end
        mode        = fm;
        fault_chunk = fch;
        word_base   = rsp_cnt;
        exp_err     = (fm != 0);
        exp_total   = 0;
        exp_lat     = 0;
        if (fm == 1) begin
            exp_starts = 1;
            exp_lat    = TIMEOUT + 2;
        end else begin
            exp_starts = (fm == 0) ? NCHUNK : fch + 1;
            if (fm == 2) dly[fch] = 40;
            for (int k = 0; k < exp_starts; k++) begin
                if (fm == 0 || k < fch) exp_total += $countones(ch[k]);
                exp_lat += (fm == 2 && k == fch) ? TIMEOUT + 3 : dly[k] + 2;
            end
        end

        @(negedge clk);
        dato = d;
        go   = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        chk("go_clears_total", 32'(total), 0);
        chk("go_clears_error", 32'(error), 0);

        n = 0; nstart = 0; seen = 1'b0;
        while (n <= exp_lat + 20) begin
            if (start) begin
                if (nstart < NCHUNK) chk("valor_at_start", 32'(Valor), 32'(ch[nstart]));
                nstart++;
            end else if (nstart > 0 && nstart <= NCHUNK) begin
                chk("valor_stable", 32'(Valor), 32'(ch[nstart-1]));
            end
            chk("busy_high", 32'(busy), 1);
            if (dup_go) begin
                go   = (n >= 1 && n <= 3);
                dato = go ? ~d : d;
            end
            @(posedge clk); #1;
            n++;
            if (listo) begin
                seen = 1'b1;
                break;
            end
        end
        go = 1'b0;

        chk("listo_seen",   32'(seen), 1);
        chk("latency",      32'(n), 32'(exp_lat));
        chk("start_count",  32'(nstart), 32'(exp_starts));
        chk("total",        32'(total), 32'(exp_total));
        chk("error",        32'(error), 32'(exp_err));
        chk("busy_in_done", 32'(busy), 1);

        // a go in the listo cycle must be ignored
        dato = ~d;
        go   = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        chk("listo_one_cycle", 32'(listo), 0);
        chk("busy_idle",       32'(busy), 0);
        chk("total_held",      32'(total), 32'(exp_total));
        chk("error_held",      32'(error), 32'(exp_err));
        @(posedge clk); #1;
        chk("go_at_listo_ignored", 32'(start | busy), 0);

        n = 0;
        while (fin !== 1'b1 && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        chk("counter_drained", 32'(fin), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, nstart;
        reset = 1'b1;
        go    = 1'b0;
        dato  = 12'h000;
        for (int k = 0; k < NCHUNK; k++) dly[k] = 2;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",  32'(busy), 0);
        chk("reset_start", 32'(start), 0);
        chk("reset_listo", 32'(listo), 0);
        chk("reset_error", 32'(error), 0);
        chk("reset_total", 32'(total), 0);
        chk("reset_valor", 32'(Valor), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_word(12'hFFF, 0, 0, 1'b0);
        run_word(12'h000, 0, 0, 1'b0);
        run_word(12'b101_000_011_001, 0, 0, 1'b0);

        // counter hung with fin high: WAIT_BUSY timeout, nothing accumulated
        run_word(12'hABC, 1, 0, 1'b0);
        // fin never returns on chunk 2: WAIT_FIN timeout keeps partial sum
        run_word(12'($urandom), 2, 2, 1'b0);
        // out-of-range Cuenta on a random chunk
        run_word(12'($urandom), 3, int'($urandom_range(3, 0)), 1'b0);

        // reset while waiting for fin on chunk 2
        mode      = 0;
        word_base = rsp_cnt;
        for (int k = 0; k < NCHUNK; k++) dly[k] = 5;
        @(negedge clk);
        dato = 12'h7E5;
        go   = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        nstart = start ? 1 : 0;
        n = 0;
        while (nstart < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (start) nstart++;
        end
        chk("reach_chunk2", 32'(nstart), 3);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_busy",  32'(busy), 0);
        chk("midreset_total", 32'(total), 0);
        chk("midreset_start", 32'(start), 0);
        chk("midreset_listo", 32'(listo), 0);
        chk("midreset_error", 32'(error), 0);
        chk("midreset_valor", 32'(Valor), 0);
        reset = 1'b0;
        n = 0;
        while (fin !== 1'b1 && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        run_word(12'h5A3, 0, 0, 1'b0);

        // go pulsed while busy must not disturb the result
        run_word(12'h39C, 0, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_word(12'($urandom), 0, 0, i[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
